vga_timing_gen_param: RTL

Parametrised VGA raster timing generator, the successor to `vga_timing_gen`. It produces horizontal/vertical sync, active-video flag and pixel coordinates for any mode described by its parameters, and adds:
- a pixel clock-enable, so one system clock can drive lower pixel rates;
- configurable sync polarity;
- registered one-clock `line_start`/`frame_start` strobes;
- a wrapping frame counter.

It sits between the system clock domain and the pixel pipeline (pattern/framebuffer readers and the VGA output pins).

---
 rtl/vga_timing_gen_param.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA raster timing generator with pixel clock-enable, selectable sync polarity,
// registered line/frame start strobes and a wrapping frame counter. All outputs are registered.
module vga_timing_gen_param #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   X_W      = 10,
    parameter int   Y_W      = 9,
    parameter int   FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic               hs,
    output logic               vs,
    output logic               active,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

    // Decode thresholds held at 32 bits so a zero back porch cannot overflow the counter width.
    localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] HS_BEG    = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] VS_BEG    = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [HC_W-1:0]    h_cnt_q, h_cnt_d;
    logic [VC_W-1:0]    v_cnt_q, v_cnt_d;
    logic [FRAME_W-1:0] frame_reg_q, frame_reg_d;

    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               active_q, active_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [31:0] h_pos;
    logic [31:0] v_pos;
    logic        in_active;
    logic        in_hsync;
    logic        in_vsync;

    always_comb begin
        h_pos     = 32'(h_cnt_q);
        v_pos     = 32'(v_cnt_q);
        in_active = (h_pos < H_ACT_END) && (v_pos < V_ACT_END);
        in_hsync  = (h_pos >= HS_BEG) && (h_pos < HS_END);
        in_vsync  = (v_pos >= VS_BEG) && (v_pos < VS_END);
    end

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_reg_d   = frame_reg_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_cnt_d   = frame_cnt_q;
        // Strobes fall on the very next clk even when the pixel enable is low.
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (ce) begin
            hs_d          = in_hsync ? HS_POL : ~HS_POL;
            vs_d          = in_vsync ? VS_POL : ~VS_POL;
            active_d      = in_active;
            x_d           = in_active ? X_W'(h_cnt_q) : '0;
            y_d           = in_active ? Y_W'(v_cnt_q) : '0;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            frame_cnt_d   = frame_reg_q;

            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d     = '0;
                    frame_reg_d = frame_reg_q + 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_reg_q   <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_reg_q   <= frame_reg_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
